// File: rtl/csa_resolve_32.sv
// Two-stage carry-propagate resolver for carry-save pairs, with Q15 extraction.
// Define CSA_ROUND_EN to round half-up instead of truncating the Q15 result.
module csa_resolve_32 #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_c,
    input  logic [31:0]      in_s,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_prod,
    output logic [15:0]      out_q15,
    output logic [TAG_W-1:0] out_tag
);

    logic             r_v1;
    logic             r_v2;
    logic [15:0]      r_lo;
    logic             r_k;
    logic [15:0]      r_s_hi;
    logic [15:0]      r_c_hi;
    logic [TAG_W-1:0] r_tag1;
    logic [31:0]      r_prod;
    logic [15:0]      r_q15;
    logic [TAG_W-1:0] r_tag2;

    logic             w_ld1;
    logic             w_ld2;
    logic [16:0]      w_lo;
    logic [15:0]      w_hi;
    logic [31:0]      w_prod;
    logic [15:0]      w_q_base;
    logic [15:0]      w_q;
    logic [15:0]      w_q15;

    assign in_ready  = !r_v1 || !r_v2 || out_ready;
    assign w_ld1     = in_valid && in_ready;
    assign w_ld2     = r_v1 && (!r_v2 || out_ready);
    assign out_valid = r_v2;
    assign out_prod  = r_prod;
    assign out_q15   = r_q15;
    assign out_tag   = r_tag2;

    assign w_lo   = {1'b0, in_s[15:0]} + {1'b0, in_c[14:0], 1'b0};
    assign w_hi   = r_s_hi + r_c_hi + {15'd0, r_k};
    assign w_prod = {w_hi, r_lo};

    assign w_q_base = w_prod[30:15];

`ifdef CSA_ROUND_EN
    // The rounding increment never wraps the positive limit.
    assign w_q = (w_q_base == 16'h7FFF) ? w_q_base
                                        : w_q_base + {15'd0, w_prod[14]};
`else
    assign w_q = w_q_base;
`endif

    always_comb begin
        w_q15 = w_q;
        if (!w_prod[31] && w_prod[30]) begin
            w_q15 = 16'h7FFF;
        end else if (w_prod[31] && !w_prod[30]) begin
            w_q15 = 16'h8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_ld1) begin
                r_v1 <= 1'b1;
            end else if (w_ld2) begin
                r_v1 <= 1'b0;
            end
            if (w_ld2) begin
                r_v2 <= 1'b1;
            end else if (out_ready) begin
                r_v2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo   <= '0;
            r_k    <= 1'b0;
            r_s_hi <= '0;
            r_c_hi <= '0;
            r_tag1 <= '0;
        end else if (w_ld1) begin
            r_lo   <= w_lo[15:0];
            r_k    <= w_lo[16];
            r_s_hi <= in_s[31:16];
            r_c_hi <= in_c[30:15];
            r_tag1 <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_q15  <= '0;
            r_tag2 <= '0;
        end else if (w_ld2) begin
            r_prod <= w_prod;
            r_q15  <= w_q15;
            r_tag2 <= r_tag1;
        end
    end

endmodule

// File: tb/tb_csa_resolve_32.sv
// Bench for csa_resolve_32: directed vectors plus an arithmetic scoreboard.
// Build with +define+CSA_ROUND_EN to exercise the rounding variant.
module tb_csa_resolve_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_c = '0;
    logic [31:0] in_s = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_prod;
    logic [15:0] out_q15;
    logic [3:0]  out_tag;

    int n_assert = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] prod;
        logic [15:0] q15;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];

    csa_resolve_32 #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .in_s      (in_s),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_q15   (out_q15),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
        end
    endtask

    // Q15 as a clamped fixed-point value: floor(p / 2^15), optionally +0.5.
    function automatic logic [15:0] model_q15(input logic [31:0] p);
        longint v;
        v = longint'($signed(p));
`ifdef CSA_ROUND_EN
        v = v + 64'sd16384;
`endif
        v = v >>> 15;
        if (v > 64'sd32767) v = 64'sd32767;
        if (v < -64'sd32768) v = -64'sd32768;
        return v[15:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            exp_t e;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                e.prod = in_s + (in_c << 1);
                e.q15  = model_q15(e.prod);
                e.tag  = in_tag;
                exp_q.push_back(e);
            end
        end
    end

    logic        stall = 1'b0;
    logic [31:0] held_prod;
    logic [15:0] held_q15;
    logic [3:0]  held_tag;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            chk("in_ready", {31'd0, in_ready},
                {31'd0, (exp_q.size() < 2) || out_ready});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    chk("sb_prod", out_prod, exp_q[0].prod);
                    chk("sb_q15", {16'd0, out_q15}, {16'd0, exp_q[0].q15});
                    chk("sb_tag", {28'd0, out_tag}, {28'd0, exp_q[0].tag});
                end
            end
            if (stall) begin
                chk("hold_prod", out_prod, held_prod);
                chk("hold_q15", {16'd0, out_q15}, {16'd0, held_q15});
                chk("hold_tag", {28'd0, out_tag}, {28'd0, held_tag});
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
            end
            stall     = out_valid && !out_ready;
            held_prod = out_prod;
            held_q15  = out_q15;
            held_tag  = out_tag;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [31:0] s, input logic [31:0] c,
                        input logic [3:0] t);
        logic ok;
        int   n;
        in_s     = s;
        in_c     = c;
        in_tag   = t;
        in_valid = 1'b1;
        n = 0;
        do begin
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [31:0] s,
                              input logic [31:0] c, input logic [31:0] prod,
                              input logic [15:0] q15, input logic chk_q);
        out_ready = 1'b1;
        send(s, c, 4'hA);
        step();
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_prod"}, out_prod, prod);
        if (chk_q) chk({name, "_q15"}, {16'd0, out_q15}, {16'd0, q15});
        step();
    endtask

    initial begin
        #23;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_prod", out_prod, 32'd0);
        chk("rst_q15", {16'd0, out_q15}, 32'd0);
        chk("rst_tag", {28'd0, out_tag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic product and latency.
        send(32'h0000FFFF, 32'h00000001, 4'h5);
        chk("lat_early", {31'd0, out_valid}, 32'd0);
        step();
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_prod", out_prod, 32'h00010001);
        chk("basic_tag", {28'd0, out_tag}, 32'h5);
        step();

        expect_out("carry", 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                   16'h0, 1'b0);
        expect_out("satpos", 32'h40000000, 32'h0, 32'h40000000,
                   16'h7FFF, 1'b1);
        expect_out("satneg", 32'hBFFFFFFF, 32'h0, 32'hBFFFFFFF,
                   16'h8000, 1'b1);
`ifdef CSA_ROUND_EN
        expect_out("round", 32'h00004000, 32'h0, 32'h00004000,
                   16'h0001, 1'b1);
        expect_out("round_lim", 32'h3FFFFFFF, 32'h0, 32'h3FFFFFFF,
                   16'h7FFF, 1'b1);
`else
        expect_out("round", 32'h00004000, 32'h0, 32'h00004000,
                   16'h0000, 1'b1);
        expect_out("trunc_lim", 32'h3FFFFFFF, 32'h0, 32'h3FFFFFFF,
                   16'h7FFF, 1'b1);
`endif

        // Backpressure: two accepted, then stall, then drain in order.
        out_ready = 1'b0;
        send(32'h00001111, 32'h00000010, 4'h1);
        send(32'h00002222, 32'h00000020, 4'h2);
        in_s = 32'h00003333; in_c = 32'h30; in_tag = 4'h3;
        in_valid = 1'b1;
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        repeat (3) step();
        chk("bp_head", {28'd0, out_tag}, 32'h1);
        out_ready = 1'b1;
        #1;
        chk("bp_comb_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_2", {28'd0, out_tag}, 32'h2);
        chk("bp_2v", {31'd0, out_valid}, 32'd1);
        step();
        chk("bp_3", {28'd0, out_tag}, 32'h3);
        chk("bp_3v", {31'd0, out_valid}, 32'd1);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Random traffic with varying backpressure.
        for (int i = 0; i < 24; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send($urandom, $urandom, 4'($urandom_range(0, 15)));
        end
        out_ready = 1'b1;
        repeat (4) step();

        // Reset with both stages full.
        out_ready = 1'b0;
        send(32'h12345678, 32'h1, 4'h6);
        send(32'h87654321, 32'h2, 4'h7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_prod", out_prod, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        send(32'h00000100, 32'h00000080, 4'h9);
        chk("post_rst_early", {31'd0, out_valid}, 32'd0);
        step();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_tag", {28'd0, out_tag}, 32'h9);
        chk("post_rst_prod", out_prod, 32'h00000200);
        step();
        chk("post_rst_alone", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_resolve_32.md
# csa_resolve_32

Carry-save resolver for the FFT butterfly multiplier. It takes the 32-bit carry/sum vector pair produced by the 8-input Wallace compression stage and performs the final carry-propagate addition in a two-stage pipeline. It produces the full 32-bit signed product and a saturated Q15 result. It sits between the Wallace compressor and the butterfly add/sub stage, and moves data with a valid/ready handshake.

## Interface
- `TAG_W`, default 4: width of the opaque sideband tag carried alongside each operand pair.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `in_valid`  in  1: `in_c`, `in_s` and `in_tag` hold a valid operand pair.
- `in_ready`  out  1: the block accepts the pair this cycle.
- `in_c`  in  32: carry vector from the compressor. Bit j carries into column j+1.
- `in_s`  in  32: sum vector from the compressor.
- `in_tag`  in  TAG_W: sideband tag, passed through unchanged.
- `out_valid`  out  1: the result outputs are valid.
- `out_ready`  in  1: the downstream stage consumes the result.
- `out_prod`  out  32: `in_s + (in_c << 1)` mod 2^32. `in_c[31]` is discarded.
- `out_q15`  out  16: Q15 result with saturation; see Operation.
- `out_tag`  out  TAG_W: tag of the result currently presented.

## Operation
- Stage 1 (low half):
  - Compute `lo = in_s[15:0] + {in_c[14:0],1'b0}` as 17 bits.
  - Register `lo[15:0]`, carry `k = lo[16]`, `in_s[31:16]`, `in_c[30:15]` and the tag.
- Stage 2 (high half):
  - Compute `hi = s_hi + c_hi + k` mod 2^16.
  - Form `prod = {hi, lo}`.
  - Form `out_q15` from `prod`, then register all outputs.
- Q15 extraction:
  - Base value is `q = prod[30:15]`.
  - Positive overflow: if `prod[31]==0` and `prod[30]==1`, saturate to 0x7FFF.
  - Negative overflow: if `prod[31]==1` and `prod[30]==0`, saturate to 0x8000.
  - The rounding option is described under Configuration. Rounding never wraps: a rounded 0x7FFF stays 0x7FFF.
- Pipeline control:
  - Each stage has a valid flag, `v1` and `v2`.
  - `out_valid = v2`.
  - Stage 2 loads when `v1 && (!v2 || out_ready)`.
  - `in_ready = !v1 || !v2 || out_ready`. This is the usual "next slot free or draining" rule and must be combinational, with no extra bubble.
  - Stage 1 loads on `in_valid && in_ready`. When stage 1 moves forward and nothing new is accepted, `v1` clears.
  - Stage 2 clears on `out_ready` when there is no incoming stage-1 data.
- Output stability: while `out_valid && !out_ready`, `out_prod`, `out_q15` and `out_tag` hold stable.
- Data registers need not be reset; valid flags must be.

## Timing
- Reset values: `v1=0`, `v2=0`, `out_valid=0`, `in_ready=1`, `out_prod=0`, `out_q15=0`, `out_tag=0`.
- Reset asserted mid-operation discards all in-flight data. After release, `in_ready=1` on the first edge.
- Latency: 2 cycles from an accepted input to `out_valid`, with no backpressure.
- Throughput: 1 result per cycle while `out_ready=1`.
- Capacity: 2 entries. With `out_ready=0`, exactly two pairs are accepted, then `in_ready` drops.
- Simultaneous accept and drain in a full pipe: both stages advance in the same cycle, with no loss and no duplication.
- `in_ready` depends combinationally on `out_ready`. No other input-to-output combinational path exists.

## Configuration
- `CSA_ROUND_EN` defined: round half-up.
  - `q = prod[30:15] + prod[14]`, with the +1 saturating at 0x7FFF.
  - The overflow saturation above still applies.
- `CSA_ROUND_EN` undefined: truncate.
  - `q = prod[30:15]`, with the overflow saturation above.
- `out_prod`, latency and handshake are identical in both builds.

## Test plan
- Basic product: `in_s=0x0000FFFF`, `in_c=0x00000001` after reset, `out_ready=1`.
  - `out_prod=0x00010001` two cycles later; `out_tag` matches the input.
- Carry across halves and dropped C[31]:
  - `in_s=0xFFFFFFFF`, `in_c=0x80000000` → `out_prod=0xFFFFFFFF`.
- Q15 saturation: `in_s=0x40000000`, `in_c=0`.
  - `out_q15=0x7FFF`.
  - `in_s=0xBFFFFFFF`, `in_c=0` → `out_q15=0x8000`.
- Rounding: `in_s=0x00004000`, `in_c=0`.
  - With `CSA_ROUND_EN`: `out_q15=0x0001`.
  - Without it: `out_q15=0x0000`.
- Backpressure: hold `out_ready=0` and stream tags 1,2,3.
  - `in_ready` drops after tags 1 and 2 are accepted.
  - Set `out_ready=1`: outputs appear in order 1,2,3 with no gaps, and output data stays stable while stalled.
- Reset mid-stream: assert `rst_n=0` with both stages full.
  - `out_valid=0` immediately.
  - After release, the first new input emerges alone after 2 cycles.
